// File: rtl/fpu_pkg.sv
// Shared FP32 types, constants and classification helpers
// for the FPU datapath (add/sub and divide).
package fpu_pkg;

  localparam int         EXP_BIAS = 127;
  localparam logic [7:0] EXP_MAX  = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    DIVIDE,
    ROUND,
    DONE
  } div_state_t;

  function automatic logic is_nan(fp32_t x);
    return (x.exp == EXP_MAX) && (x.man != '0);
  endfunction

  function automatic logic is_inf(fp32_t x);
    return (x.exp == EXP_MAX) && (x.man == '0);
  endfunction

  // Denormals count as zero: the datapath flushes them.
  function automatic logic is_zero(fp32_t x);
    return x.exp == '0;
  endfunction

  function automatic fp32_t ftz(fp32_t x);
    fp32_t y;
    y = x;
    if (x.exp == '0) y.man = '0;
    return y;
  endfunction

endpackage

// File: rtl/fpu_special_detect.sv
// Special-operand classifier for FP32 divide:
// NaN, divide-by-zero, infinities and zeros.
module fpu_special_detect
  import fpu_pkg::*;
#(
  parameter logic [31:0] NAN_PAT = 32'h7FC0_0000
) (
  input  fp32_t       a,
  input  fp32_t       b,
  output logic        special,
  output logic [31:0] result,
  output logic        nan_error,
  output logic        div_by_zero
);

  logic sign;
  assign sign = a.sign ^ b.sign;

  always_comb begin
    special     = 1'b1;
    result      = '0;
    nan_error   = 1'b0;
    div_by_zero = 1'b0;
    priority case (1'b1)
      is_nan(a) || is_nan(b) ||
      (is_zero(a) && is_zero(b)) ||
      (is_inf(a) && is_inf(b)): begin
        result    = NAN_PAT;
        nan_error = 1'b1;
      end
      is_zero(b) && !is_inf(a): begin
        result      = {sign, EXP_MAX, 23'h0};
        div_by_zero = 1'b1;
      end
      is_inf(a):
        result = {sign, EXP_MAX, 23'h0};
      is_zero(a) || is_inf(b):
        result = {sign, 31'h0};
      default:
        special = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpu_div_seq.sv
// Iterative FP32 divider: restoring division, one quotient
// bit per cycle, round-to-nearest-even, flush-to-zero.
module fpu_div_seq #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000,
  parameter int          ITER = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Result,
  output logic        NaN_error,
  output logic        div_by_zero
);
  import fpu_pkg::*;

  div_state_t state, nxt;

  fp32_t             a_q, b_q, a_d, b_d;
  logic              sign;
  logic signed [9:0] exp_q, exp_n, exp_r;
  logic [23:0]       mb, ma_n, mb_n;
  logic [24:0]       rem, q, rem_n, man_r;
  logic [4:0]        cnt;
  logic              a_lt, ge, inc;
  logic              spec, spec_nan, spec_dbz;
  logic [31:0]       spec_res, res_r;

  assign a_d = ftz(a_q);
  assign b_d = ftz(b_q);

  fpu_special_detect #(
    .NAN_PAT(QNAN)
  ) u_special (
    .a          (a_d),
    .b          (b_d),
    .special    (spec),
    .result     (spec_res),
    .nan_error  (spec_nan),
    .div_by_zero(spec_dbz)
  );

  assign ma_n  = {1'b1, a_d.man};
  assign mb_n  = {1'b1, b_d.man};
  assign a_lt  = ma_n < mb_n;
  assign exp_n = 10'(a_d.exp) - 10'(b_d.exp)
               + 10'(EXP_BIAS) - 10'(a_lt);

  assign ge    = rem >= {1'b0, mb};
  assign rem_n = ge ? rem - {1'b0, mb} : rem;

  // q[0] is the guard bit; nonzero remainder is sticky.
  assign inc   = q[0] & ((rem != '0) | q[1]);
  assign man_r = {1'b0, q[24:1]} + 25'(inc);
  assign exp_r = exp_q + $signed({9'b0, man_r[24]});

  always_comb begin
    res_r = {sign, exp_r[7:0], man_r[22:0]};
    if (man_r[24]) res_r[22:0] = man_r[23:1];
    if (exp_r >= 10'sd255)
      res_r = {sign, EXP_MAX, 23'h0};
    else if (exp_r <= 10'sd0)
      res_r = {sign, 31'h0};
  end

  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   if (in_valid) nxt = UNPACK;
      UNPACK: nxt = spec ? DONE : DIVIDE;
      DIVIDE: if (cnt == 5'(ITER - 1)) nxt = ROUND;
      ROUND:  nxt = DONE;
      DONE:   if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      sign        <= 1'b0;
      exp_q       <= '0;
      mb          <= '0;
      rem         <= '0;
      q           <= '0;
      cnt         <= '0;
      Result      <= '0;
      NaN_error   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_q <= A;
          b_q <= B;
        end
        UNPACK: begin
          sign <= a_q.sign ^ b_q.sign;
          if (spec) begin
            Result      <= spec_res;
            NaN_error   <= spec_nan;
            div_by_zero <= spec_dbz;
          end else begin
            rem   <= a_lt ? {ma_n, 1'b0} : {1'b0, ma_n};
            mb    <= mb_n;
            exp_q <= exp_n;
            q     <= '0;
            cnt   <= '0;
          end
        end
        DIVIDE: begin
          rem <= {rem_n[23:0], 1'b0};
          q   <= {q[23:0], ge};
          cnt <= cnt + 5'd1;
        end
        ROUND: begin
          Result      <= res_r;
          NaN_error   <= 1'b0;
          div_by_zero <= 1'b0;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_div_seq.sv
// Randomized + directed bench for fpu_div_seq against an
// integer-arithmetic quotient model.
module tb_fpu_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        in_ready, out_valid;
  logic [31:0] Result;
  logic        NaN_error, div_by_zero;

  int errs = 0;
  int checks = 0;

  fpu_div_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (Result),
    .NaN_error  (NaN_error),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {special, nan, dbz, result}.
  function automatic logic [34:0] ref_div(input logic [31:0] a,
                                          input logic [31:0] b);
    logic s, za, zb, ia, ib, na, nb;
    int ea, eb, e, p, drop;
    longint unsigned num, den, qt, rm, kept, low, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    za = ea == 0;
    zb = eb == 0;
    ia = ea == 255 && a[22:0] == 0;
    ib = eb == 255 && b[22:0] == 0;
    na = ea == 255 && a[22:0] != 0;
    nb = eb == 255 && b[22:0] != 0;
    if (na || nb || (za && zb) || (ia && ib))
      return {3'b110, 32'h7FC00000};
    if (zb && !ia) return {3'b101, s, 8'hFF, 23'h0};
    if (ia) return {3'b100, s, 8'hFF, 23'h0};
    if (za || ib) return {3'b100, s, 31'h0};
    num  = {41'd1, a[22:0]} << 30;
    den  = {41'd1, b[22:0]};
    qt   = num / den;
    rm   = num % den;
    p    = (qt >= (64'd1 << 30)) ? 30 : 29;
    e    = ea - eb + 127 + (p - 30);
    drop = p - 23;
    kept = qt >> drop;
    low  = qt & ((64'd1 << drop) - 1);
    half = 64'd1 << (drop - 1);
    if (low > half || (low == half && (rm != 0 || kept[0])))
      kept++;
    if (kept == (64'd1 << 24)) begin
      kept = kept >> 1;
      e++;
    end
    if (e >= 255) return {3'b000, s, 8'hFF, 23'h0};
    if (e <= 0) return {3'b000, s, 31'h0};
    return {3'b000, s, 8'(e), kept[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0]  e;
    logic [22:0] f;
    int k;
    k = int'($urandom_range(0, 15));
    if (k == 0)      e = 8'd0;
    else if (k == 1) e = 8'd255;
    else if (k == 2) e = 8'd1;
    else if (k == 3) e = 8'd254;
    else             e = 8'($urandom_range(90, 165));
    f = 23'($urandom);
    if ($urandom_range(0, 7) == 0) f = '0;
    return {1'($urandom), e, f};
  endfunction

  // Called at a negedge with the DUT idle; out_ready high.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res,
                        output logic nan, output logic dbz,
                        output int lat);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) chk("timeout", 32'(lat), 32'd28);
    res = Result;
    nan = NaN_error;
    dbz = div_by_zero;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_op(input string tag,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [34:0] exp);
    logic [31:0] res;
    logic nan, dbz;
    int lat;
    run_op(a, b, res, nan, dbz, lat);
    chk({tag, ".res"}, res, exp[31:0]);
    chk({tag, ".nan"}, 32'(nan), 32'(exp[33]));
    chk({tag, ".dbz"}, 32'(dbz), 32'(exp[32]));
    chk({tag, ".lat"}, 32'(lat), exp[34] ? 32'd2 : 32'd28);
  endtask

  logic [31:0] dir_a [12] = '{
    32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h00000000,
    32'h40A00000, 32'h7F800000, 32'h7F7FFFFF, 32'h00800000,
    32'h7F800000, 32'h3F800000, 32'h7FA00000, 32'h40000000};
  logic [31:0] dir_b [12] = '{
    32'h40000000, 32'h40400000, 32'h40400000, 32'h00000000,
    32'h00000000, 32'h7F800000, 32'h3F000000, 32'h40000000,
    32'h80000000, 32'h7F800000, 32'h3F800000, 32'h40000000};
  logic [34:0] dir_e [12] = '{
    {3'b000, 32'h40400000}, {3'b000, 32'h3EAAAAAB},
    {3'b000, 32'hBEAAAAAB}, {3'b110, 32'h7FC00000},
    {3'b101, 32'h7F800000}, {3'b110, 32'h7FC00000},
    {3'b000, 32'h7F800000}, {3'b000, 32'h00000000},
    {3'b100, 32'hFF800000}, {3'b100, 32'h00000000},
    {3'b110, 32'h7FC00000}, {3'b000, 32'h3F800000}};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b, res;
    logic nan, dbz;
    int lat, n;

    repeat (2) @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result", Result, 32'h0);
    chk("rst.nan", 32'(NaN_error), 32'd0);
    chk("rst.dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      check_op($sformatf("dir%0d", i), dir_a[i], dir_b[i], dir_e[i]);

    for (int i = 0; i < 60; i++) begin
      a = rnd_fp();
      b = rnd_fp();
      check_op($sformatf("rnd%0d_%h_%h", i, a, b), a, b, ref_div(a, b));
    end

    out_ready = 1'b0;
    A = 32'h40C00000;
    B = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (n < 100 && !out_valid) begin
      @(negedge clk);
      n++;
    end
    chk("bp.lat", 32'(n), 32'd28);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      A = 32'h3F800000;
      B = 32'h40400000;
      @(negedge clk);
      chk("bp.hold", Result, 32'h40400000);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.release_ready", 32'(in_ready), 32'd1);
    chk("bp.release_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp.ghost", 32'(out_valid), 32'd0);
    end

    A = 32'h40C00000;
    B = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.in_ready", 32'(in_ready), 32'd1);
    chk("mid.result", Result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid.idle", 32'(out_valid), 32'd0);
    run_op(32'h40C00000, 32'h40000000, res, nan, dbz, lat);
    chk("post.res", res, 32'h40400000);
    chk("post.lat", 32'(lat), 32'd28);
    chk("post.flags", {30'b0, nan, dbz}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fpu_div_seq.md
Name: fpu_div_seq

Overview:
- Iterative IEEE-754 single-precision divider, Result = A / B.
- It is the multi-cycle inverse-operation counterpart to the combinational add/subtract FPUs, and sits beside them in the FPU datapath.
- Valid/ready handshakes on both the input side and the output side.
- Carries the same NaN_error flag convention as the add/subtract FPUs, plus a divide-by-zero flag.

Parameters:
- QNAN, 32'h7FC0_0000, canonical quiet-NaN pattern driven on invalid operations.
- ITER, 25, mantissa quotient iterations (24 significand bits + 1 guard bit); not intended to be overridden.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset: asynchronous assertion, active-low.
- in_valid  input  1  A/B valid.
- in_ready  output  1  block can accept operands.
- A  input  32  dividend, IEEE-754.
- B  input  32  divisor, IEEE-754.
- out_valid  output  1  Result and flags valid.
- out_ready  input  1  consumer accepts the result.
- Result  output  32  quotient, IEEE-754.
- NaN_error  output  1  result is NaN: NaN input, 0/0, or inf/inf.
- div_by_zero  output  1  nonzero finite divided by zero.

Behaviour:
- Reset is asynchronous and active-low: one clock, clk; reset rst_n.
- Reset values:
  - in_ready=1, out_valid=0, Result=0, NaN_error=0, div_by_zero=0, state=IDLE.
- Reset mid-operation:
  - Any in-flight division is abandoned and the block returns to IDLE.
  - No output is produced for it.
- States: IDLE, UNPACK, DIVIDE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - An accept occurs when in_valid and in_ready are both high at a rising edge (cycle T); A and B are registered.
  - Go to UNPACK.
- UNPACK (T+1):
  - Decode sign, exponent and mantissa of each operand.
  - Denormal inputs are flushed to signed zero.
  - Sign = A[31]^B[31].
  - Special-case priority:
    1. Either operand NaN, 0/0, or inf/inf: Result=QNAN, NaN_error=1.
    2. Finite nonzero / 0: Result={sign,8'hFF,23'h0}, div_by_zero=1.
    3. inf / finite: signed inf.
    4. 0 / nonzero, or finite / inf: signed zero.
  - Any special case goes straight to DONE, so out_valid rises at T+2.
  - Otherwise, normal case:
    - Form 24-bit mantissas with the hidden 1.
    - If mA<mB, shift mA left by 1 and apply an exponent adjust of -1.
    - Exponent = eA-eB+127+adj, computed as a 10-bit signed value.
    - Go to DIVIDE.
- DIVIDE (T+2..T+26):
  - Restoring division, one quotient bit per cycle, for ITER cycles.
  - A 5-bit iteration counter counts 0..24.
  - Partial remainder is 25 bits wide.
  - At the end: quotient q[24:0] lies in [1,2) (q[24]=1), and sticky = (remainder != 0).
- ROUND (T+27):
  - Round to nearest even on {q[0] as guard, sticky}.
  - If the increment carries out of the mantissa: mantissa becomes 1.0 and exponent +1.
  - Exponent >= 255 after rounding: signed inf, NaN_error=0.
  - Exponent <= 0: signed zero (flush-to-zero).
  - Go to DONE.
- DONE:
  - out_valid=1.
  - Result and flags are held stable until out_valid and out_ready are both high at an edge; then go to IDLE.
  - in_ready=0 in every state except IDLE; there is no overlap of operations.
- Latency:
  - Normal case: out_valid at T+28.
  - Special case: out_valid at T+2.
  - With out_ready tied high, throughput is one result per 29 cycles (normal) or 3 cycles (special).
- Flags:
  - NaN_error and div_by_zero are mutually exclusive.
  - Both are 0 for every non-special result.

Decomposition:
- Shared package fpu_pkg:
  - fp32_t packed struct {sign, exp[7:0], man[22:0]}.
  - Constants EXP_BIAS=127, EXP_MAX=8'hFF, QNAN, POS_INF.
  - div_state_t enum.
  - Functions is_nan, is_inf, is_zero. These are reusable by the add/subtract FPUs.
- One natural sub-module: fpu_special_detect.
  - Combinational.
  - Takes the two decoded operands.
  - Returns special-case flag, special Result, NaN_error and div_by_zero.

Test Plan:
- 6.0/2.0: A=0x40C00000, B=0x40000000, out_ready=1 → Result=0x40400000 at T+28; NaN_error=0, div_by_zero=0.
- 1.0/3.0: A=0x3F800000, B=0x40400000 → Result=0x3EAAAAAB (RNE rounds up); -1.0/3.0 (A=0xBF800000) → 0xBEAAAAAB.
- Specials, each with out_valid at T+2:
  - 0/0 (0x00000000/0x00000000) → 0x7FC00000, NaN_error=1.
  - 5.0/+0 (0x40A00000/0x00000000) → 0x7F800000, div_by_zero=1.
  - 0x7F800000/0x7F800000 → QNAN, NaN_error=1.
- Range limits:
  - Overflow: 0x7F7FFFFF / 0x3F000000 (0.5) → 0x7F800000 with both flags 0.
  - Underflow: 0x00800000 / 0x40000000 → 0x00000000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → Result stable, in_ready=0, and new in_valid is ignored. Raise out_ready → in_ready=1 on the next cycle.
- Reset mid-DIVIDE: drop rst_n at T+10 → out_valid=0, in_ready=1 immediately. After release, a new 6.0/2.0 returns 0x40400000 at the correct latency.
